// File: rtl/simple_isa_pkg.sv
// simple_isa_pkg: instruction classes, op3 codes, phase indices and execute FSM states
package simple_isa_pkg;
  localparam logic [1:0] CL_LD  = 2'b00;
  localparam logic [1:0] CL_ST  = 2'b01;
  localparam logic [1:0] CL_LI  = 2'b10;
  localparam logic [1:0] CL_ALU = 2'b11;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SLR = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;
  localparam logic [3:0] OP_SRA = 4'hB;
  localparam logic [3:0] OP_IN  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int P3 = 2;
  localparam int P4 = 3;
  localparam int P5 = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction
endpackage

// File: rtl/shifter_unit.sv
// shifter_unit: barrel shifter, or one-bit-per-clock serial shifter when SERIAL_SHIFT_EN is defined
module shifter_unit #(
  parameter int WIDTH = 16,
  parameter int SHAMT_W = 4
) (
`ifdef SERIAL_SHIFT_EN
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  output logic               o_last,
`endif
  input  logic [1:0]         i_kind,
  input  logic [SHAMT_W-1:0] i_d,
  input  logic [WIDTH-1:0]   i_val,
  output logic [WIDTH-1:0]   o_res,
  output logic               o_c
);
`ifdef SERIAL_SHIFT_EN
  logic [WIDTH-1:0] r_sh;
  logic [SHAMT_W-1:0] r_cnt;
  logic [1:0] r_kind;
  // o_res is the next single-bit step of the shift register
  assign o_res = r_kind[1] ? {r_kind[0] & r_sh[WIDTH-1], r_sh[WIDTH-1:1]}
                           : {r_sh[WIDTH-2:0], r_kind[0] & r_sh[WIDTH-1]};
  assign o_c = r_kind[1] ? r_sh[0] : r_sh[WIDTH-1];
  assign o_last = r_cnt == SHAMT_W'(1);
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sh <= '0;
      r_cnt <= '0;
      r_kind <= '0;
    end else if (i_load) begin
      r_sh <= i_val;
      r_cnt <= i_d;
      r_kind <= i_kind;
    end else if (r_cnt != '0) begin
      r_sh <= o_res;
      r_cnt <= r_cnt - 1'b1;
    end
  end
`else
  logic [2*WIDTH-1:0] w_l, w_rl;
  logic signed [2*WIDTH-1:0] w_ra;
  // double-width shifts leave the last bit shifted out just across the word boundary
  assign w_l = {{WIDTH{1'b0}}, i_val} << i_d;
  assign w_rl = {i_val, {WIDTH{1'b0}}} >> i_d;
  assign w_ra = $signed({i_val, {WIDTH{1'b0}}}) >>> i_d;
  always_comb begin
    o_res = i_kind[1] ? (i_kind[0] ? w_ra[2*WIDTH-1:WIDTH] : w_rl[2*WIDTH-1:WIDTH])
                      : (w_l[WIDTH-1:0] | (i_kind[0] ? w_l[2*WIDTH-1:WIDTH] : '0));
    o_c = i_kind[1] ? (i_kind[0] ? w_ra[WIDTH-1] : w_rl[WIDTH-1]) : w_l[WIDTH];
  end
`endif
endmodule

// File: rtl/alu_execute.sv
// alu_execute: execute stage latching DR and S/Z/C/V at p3; SERIAL_SHIFT_EN selects serial shifts with stall
module alu_execute
  import simple_isa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       phasecounter,
  input  logic [15:0]      command,
  input  logic [WIDTH-1:0] AR,
  input  logic [WIDTH-1:0] BR,
  input  logic [WIDTH-1:0] ext_in,
  output logic [WIDTH-1:0] DR,
  output logic             S,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             stall
);
  logic [1:0] w_cls;
  logic [3:0] w_op;
  logic [SHAMT_W-1:0] w_d;
  logic w_p3, w_go, w_shift, w_sh_c, w_c, w_v, w_wr_dr, w_wr_fl;
  logic [WIDTH:0] w_sum, w_dif;
  logic [WIDTH-1:0] w_imm, w_res, w_sh_res;
  assign w_cls = command[15:14];
  assign w_op = command[7:4];
  assign w_d = command[SHAMT_W-1:0];
  assign w_p3 = phasecounter[P3];
  assign w_imm = {{(WIDTH-8){command[7]}}, command[7:0]};
  assign w_sum = {1'b0, BR} + {1'b0, AR};
  assign w_dif = {1'b0, BR} - {1'b0, AR};
  assign w_shift = (w_cls == CL_ALU) && is_shift(w_op);
`ifdef SERIAL_SHIFT_EN
  state_t r_state, w_next;
  logic w_start, w_last;
  assign w_go = w_p3 && (r_state == IDLE);
  assign w_start = w_go && w_shift && (w_d != '0);
  always_ff @(posedge clock) r_state <= !reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    stall = reset && (w_start || r_state == SHIFT);
    if (w_start) w_next = SHIFT;
    else if (r_state == SHIFT && w_last) w_next = DONE;
    else if (r_state == DONE && !w_p3) w_next = IDLE;
  end
  shifter_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .clock(clock), .reset(reset), .i_load(w_start), .o_last(w_last),
    .i_kind(w_op[1:0]), .i_d(w_d), .i_val(BR), .o_res(w_sh_res), .o_c(w_sh_c)
  );
`else
  assign w_go = w_p3;
  assign stall = 1'b0;
  shifter_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .i_kind(w_op[1:0]), .i_d(w_d), .i_val(BR), .o_res(w_sh_res), .o_c(w_sh_c)
  );
`endif
  always_comb begin
    w_res = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    w_wr_dr = 1'b0;
    w_wr_fl = 1'b0;
    if (w_cls == CL_ALU) begin
      w_wr_dr = 1'b1;
      w_wr_fl = 1'b1;
      case (w_op)
        OP_ADD: begin
          w_res = w_sum[WIDTH-1:0];
          w_c = w_sum[WIDTH];
          w_v = (BR[WIDTH-1] == AR[WIDTH-1]) && (w_sum[WIDTH-1] != BR[WIDTH-1]);
        end
        OP_SUB, OP_CMP: begin
          w_res = w_dif[WIDTH-1:0];
          w_c = w_dif[WIDTH];
          w_v = (BR[WIDTH-1] != AR[WIDTH-1]) && (w_dif[WIDTH-1] != BR[WIDTH-1]);
          w_wr_dr = w_op == OP_SUB;
        end
        OP_AND: w_res = BR & AR;
        OP_OR:  w_res = BR | AR;
        OP_XOR: w_res = BR ^ AR;
        OP_MOV: w_res = AR;
        OP_IN:  w_res = ext_in;
        OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
`ifdef SERIAL_SHIFT_EN
          // only a zero-distance shift completes here; the rest go through the FSM
          w_res = BR;
          w_wr_dr = w_d == '0;
          w_wr_fl = w_d == '0;
`else
          w_res = w_sh_res;
          w_c = w_sh_c;
`endif
        end
        default: begin
          w_wr_dr = 1'b0;
          w_wr_fl = 1'b0;
        end
      endcase
    end else if (w_cls == CL_LI) begin
      w_res = w_imm;
      w_wr_dr = command[13:11] == 3'b000;
    end else begin
      w_res = BR + w_imm;
      w_wr_dr = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      DR <= '0;
      {S, Z, C, V} <= 4'b0000;
    end else begin
      if (w_go && w_wr_dr) DR <= w_res;
      if (w_go && w_wr_fl) {S, Z, C, V} <= {w_res[WIDTH-1], w_res == '0, w_c, w_v};
`ifdef SERIAL_SHIFT_EN
      if (r_state == SHIFT && w_last) begin
        DR <= w_sh_res;
        {S, Z, C, V} <= {w_sh_res[WIDTH-1], w_sh_res == '0, w_sh_c, 1'b0};
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: table-driven check of alu_execute plus reset and serial-shift sequences
module tb_alu_execute;
  logic clock = 1'b0;
  logic reset;
  logic [4:0] phasecounter;
  logic [15:0] command, AR, BR, ext_in, DR;
  logic S, Z, C, V, stall;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [15:0] cmd;
    logic [15:0] ar;
    logic [15:0] br;
    logic [15:0] ext;
    logic p3;
    logic [15:0] dr;
    logic [3:0] fl;
  } vec_t;
  vec_t vt[24];
  alu_execute dut (
    .clock(clock), .reset(reset), .phasecounter(phasecounter), .command(command),
    .AR(AR), .BR(BR), .ext_in(ext_in), .DR(DR), .S(S), .Z(Z), .C(C), .V(V), .stall(stall)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [15:0] cmd, input logic [15:0] ar, input logic [15:0] br,
                       input logic [15:0] ext, input logic p3);
    command = cmd;
    AR = ar;
    BR = br;
    ext_in = ext;
    phasecounter = p3 ? 5'b00100 : 5'b00010;
    #1;
  endtask
  initial begin
    int n;
    vt[0]  = '{16'hCA00, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 4'b1001};
    vt[1]  = '{16'hC060, 16'h1234, 16'h0000, 16'h0000, 1'b1, 16'h1234, 4'b0000};
    vt[2]  = '{16'hCA50, 16'h0005, 16'h0003, 16'h0000, 1'b1, 16'h1234, 4'b1010};
    vt[3]  = '{16'hC000, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0110};
    vt[4]  = '{16'hC010, 16'h0001, 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 4'b0001};
    vt[5]  = '{16'hC020, 16'h3C3C, 16'hF0F0, 16'h0000, 1'b1, 16'h3030, 4'b0000};
    vt[6]  = '{16'hC030, 16'h3C3C, 16'hF0F0, 16'h0000, 1'b1, 16'hFCFC, 4'b1000};
    vt[7]  = '{16'hC040, 16'h3C3C, 16'hF0F0, 16'h0000, 1'b1, 16'hCCCC, 4'b1000};
    vt[8]  = '{16'hC0C0, 16'h1111, 16'h2222, 16'h0000, 1'b1, 16'h0000, 4'b0100};
    vt[9]  = '{16'hC0D0, 16'h1111, 16'h2222, 16'h5555, 1'b1, 16'h0000, 4'b0100};
    vt[10] = '{16'hC2B1, 16'h0000, 16'h8001, 16'h0000, 1'b1, 16'hC000, 4'b1010};
    vt[11] = '{16'hC2B1, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16'hC000, 4'b1010};
    vt[12] = '{16'h02FE, 16'h0000, 16'h0010, 16'h0000, 1'b1, 16'h000E, 4'b1010};
    vt[13] = '{16'h8080, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hFF80, 4'b1010};
    vt[14] = '{16'h4105, 16'h0000, 16'h1000, 16'h0000, 1'b1, 16'h1005, 4'b1010};
    vt[15] = '{16'h8880, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h1005, 4'b1010};
    vt[16] = '{16'hC283, 16'h0000, 16'h3001, 16'h0000, 1'b1, 16'h8008, 4'b1010};
    vt[17] = '{16'hC294, 16'h0000, 16'h9001, 16'h0000, 1'b1, 16'h0019, 4'b0010};
    vt[18] = '{16'hC2A8, 16'h0000, 16'h8180, 16'h0000, 1'b1, 16'h0081, 4'b0010};
    vt[19] = '{16'hC280, 16'h0000, 16'hABCD, 16'h0000, 1'b1, 16'hABCD, 4'b1000};
    vt[20] = '{16'hC010, 16'h0005, 16'h0005, 16'h0000, 1'b1, 16'h0000, 4'b0100};
    vt[21] = '{16'hC0F0, 16'h0001, 16'h0007, 16'h0000, 1'b1, 16'h0000, 4'b0100};
    vt[22] = '{16'hC2AF, 16'h0000, 16'h8000, 16'h0000, 1'b1, 16'h0001, 4'b0000};
    vt[23] = '{16'hC28F, 16'h0000, 16'h0003, 16'h0000, 1'b1, 16'h8000, 4'b1010};
    reset = 1'b0;
    drive(16'hCA00, 16'h0001, 16'h0001, 16'h0000, 1'b1);
    step();
    step();
    chk("rst_dr", DR, 16'h0000);
    chk("rst_fl", {12'h0, S, Z, C, V}, 16'h0000);
    chk("rst_stall", {15'h0, stall}, 16'h0000);
    reset = 1'b1;
    drive(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step();
    chk("idle_hold_dr", DR, 16'h0000);
    for (int i = 0; i < 24; i++) begin
      drive(vt[i].cmd, vt[i].ar, vt[i].br, vt[i].ext, vt[i].p3);
      n = 0;
      do begin
        step();
        n++;
      end while (stall && n < 40);
      if (n >= 40) chk($sformatf("timeout%0d", i), 16'(n), 16'(0));
      chk($sformatf("dr%0d", i), DR, vt[i].dr);
      chk($sformatf("fl%0d", i), {12'h0, S, Z, C, V}, {12'h0, vt[i].fl});
      chk($sformatf("stall%0d", i), {15'h0, stall}, 16'h0000);
      phasecounter = 5'b00010;
      step();
    end
    drive(16'hCA00, 16'h0003, 16'h0002, 16'h0000, 1'b1);
    reset = 1'b0;
    step();
    chk("rstpri_dr", DR, 16'h0000);
    chk("rstpri_fl", {12'h0, S, Z, C, V}, 16'h0000);
    reset = 1'b1;
    step();
    chk("add_after_rst_dr", DR, 16'h0005);
    chk("add_after_rst_fl", {12'h0, S, Z, C, V}, 16'h0000);
    phasecounter = 5'b00010;
    step();
`ifdef SERIAL_SHIFT_EN
    drive(16'hC283, 16'h0000, 16'h3001, 16'h0000, 1'b1);
    n = 0;
    while (stall && n < 40) begin
      n++;
      step();
    end
    chk("ser_stall_cycles", 16'(n), 16'd4);
    chk("ser_dr", DR, 16'h8008);
    chk("ser_fl", {12'h0, S, Z, C, V}, 16'h000A);
    BR = 16'h0001;
    #1;
    chk("done_no_stall", {15'h0, stall}, 16'h0000);
    step();
    step();
    chk("done_no_retrig", DR, 16'h8008);
    phasecounter = 5'b00010;
    step();
    drive(16'hC2A8, 16'h0000, 16'h8180, 16'h0000, 1'b1);
    step();
    step();
    chk("mid_stall", {15'h0, stall}, 16'h0001);
    reset = 1'b0;
    step();
    chk("midrst_stall", {15'h0, stall}, 16'h0000);
    chk("midrst_dr", DR, 16'h0000);
    chk("midrst_fl", {12'h0, S, Z, C, V}, 16'h0000);
    reset = 1'b1;
    phasecounter = 5'b00010;
    step();
    step();
    chk("midrst_quiet", DR, 16'h0000);
    drive(16'hCA00, 16'h0003, 16'h0002, 16'h0000, 1'b1);
    chk("add2_stall", {15'h0, stall}, 16'h0000);
    step();
    chk("add2_dr", DR, 16'h0005);
    phasecounter = 5'b00010;
    step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
